// File: rtl/mem_pair_sched.sv
// ----------------------------------------------------------------------------
// mem_pair_sched
//
// Load-then-reduce scheduler for a column-organised scratch memory.
//
// A job loads IMG_COLS column words (IMG_ROWS 32-bit lanes each) into memory
// addresses 0..IMG_COLS-1. It then runs a pairwise tree reduction: in stage s
// (span = 2^s) it issues one read pair (i, i+span) per cycle for
// i = 0, 2*span, 4*span, ... The external compute unit returns the combined
// column LAT cycles after the issue, and the result is written back to address i.
// Each stage is drained fully before the next one starts, so stage s+1 always
// reads results that are already committed. After the last stage, column 0
// holds the reduction of all columns.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   start       begin a job (sampled only in IDLE)
//   busy        high whenever the scheduler is not IDLE
//   done        one-cycle pulse when the job completes
//   in_valid    loader column valid
//   in_ready    loader column accepted when in_valid && in_ready
//   in_col      loader column data
//   op_issue    addr1/addr2 carry a valid read pair this cycle
//   res_data    compute result, valid LAT cycles after its op_issue
//   addr1/2     memory read addresses (0 when op_issue is low)
//   we          memory write enable
//   addr_write  memory write address
//   write_data  memory write data (0 when we is low)
// ----------------------------------------------------------------------------
module mem_pair_sched #(
    parameter int IMG_ROWS = 4,
    parameter int IMG_COLS = 4,
    parameter int LAT      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMG_ROWS-1:0][31:0] in_col,
    output logic                     op_issue,
    input  logic [IMG_ROWS-1:0][31:0] res_data,
    output logic [31:0]              addr1,
    output logic [31:0]              addr2,
    output logic                     we,
    output logic [31:0]              addr_write,
    output logic [IMG_ROWS-1:0][31:0] write_data
);

    localparam int AW = $clog2(IMG_COLS);             // column address width
    localparam int SW = (AW > 1) ? $clog2(AW) : 1;    // stage index width

    typedef enum logic [2:0] {IDLE, LOAD, REDUCE, DRAIN, FIN} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           load_cnt_q, load_cnt_d;
    logic [SW-1:0]           stage_q, stage_d;
    logic [AW-1:0]           idx_q, idx_d;

    // Delay line that tracks in-flight pairs: slot LAT-1 lines up with res_data.
    logic [LAT-1:0]          dl_vld_q;
    logic [LAT-1:0][AW-1:0]  dl_addr_q;

    logic [AW:0]             span;
    logic [AW:0]             idx_next;
    logic [AW-1:0]           pair_hi;
    logic [LAT-1:0]          dl_not_last;

    assign span     = (AW+1)'(1) << stage_q;
    assign idx_next = {1'b0, idx_q} + (span << 1);
    assign pair_hi  = idx_q + span[AW-1:0];

    // Entries still in flight after this cycle's writeback leaves the line.
    // The stage is finished once nothing but the outgoing slot is occupied.
    always_comb begin
        dl_not_last          = dl_vld_q;
        dl_not_last[LAT-1]   = 1'b0;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        stage_d    = stage_q;
        idx_d      = idx_q;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        in_ready   = 1'b0;
        op_issue   = 1'b0;
        addr1      = '0;
        addr2      = '0;
        we         = 1'b0;
        addr_write = '0;
        write_data = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    we         = 1'b1;
                    addr_write = 32'(load_cnt_q);
                    write_data = in_col;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == AW'(IMG_COLS - 1)) begin
                        state_d = REDUCE;
                        stage_d = '0;
                        idx_d   = '0;
                    end
                end
            end
            REDUCE: begin
                op_issue = 1'b1;
                addr1    = 32'(idx_q);
                addr2    = 32'(pair_hi);
                idx_d    = idx_next[AW-1:0];
                if (idx_next >= (AW+1)'(IMG_COLS)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (dl_not_last == '0) begin
                    if (stage_q == SW'(AW - 1)) begin
                        state_d = FIN;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = REDUCE;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Writebacks only occur while the delay line is non-empty, which is
        // confined to REDUCE/DRAIN, so they never collide with a LOAD write.
        if (dl_vld_q[LAT-1]) begin
            we         = 1'b1;
            addr_write = 32'(dl_addr_q[LAT-1]);
            write_data = res_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order of statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            stage_q    <= '0;
            idx_q      <= '0;
            dl_vld_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            stage_q    <= stage_d;
            idx_q      <= idx_d;
            for (int i = LAT - 1; i > 0; i--) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
            end
            dl_vld_q[0] <= op_issue;
        end
    end

    // NOTE: the address slots are deliberately left out of reset; they are
    // only looked at when the matching valid bit is set, and clearing those
    // valid bits is what cancels in-flight writebacks.
    always_ff @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            dl_addr_q[i] <= dl_addr_q[i-1];
        end
        dl_addr_q[0] <= idx_q;
    end

endmodule

// File: tb/tb_mem_pair_sched.sv
// ----------------------------------------------------------------------------
// tb_mem_pair_sched
//
// Directed bench for mem_pair_sched. Instance "a" uses IMG_COLS=4, LAT=2 and
// is checked cycle by cycle against hand-computed output vectors. Instance "b"
// uses IMG_COLS=8, LAT=3 and is checked against a hand-computed schedule of
// issues and writebacks. Each instance sits on a small memory model whose
// compute path returns the lane-wise sum of the two read columns LAT cycles
// after the issue.
// ----------------------------------------------------------------------------
module tb_mem_pair_sched;

    logic clk;
    logic rst;

    // ---------------- instance a: 4 columns, LAT 2 ----------------
    logic              start, busy, done, in_valid, in_ready, op_issue, we;
    logic [3:0][31:0]  in_col, res_data, write_data;
    logic [31:0]       addr1, addr2, addr_write;

    mem_pair_sched #(.IMG_ROWS(4), .IMG_COLS(4), .LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .op_issue(op_issue), .res_data(res_data), .addr1(addr1), .addr2(addr2),
        .we(we), .addr_write(addr_write), .write_data(write_data)
    );

    // ---------------- instance b: 8 columns, LAT 3 ----------------
    logic              start_b, busy_b, done_b, in_valid_b, in_ready_b, op_issue_b, we_b;
    logic [3:0][31:0]  in_col_b, res_data_b, write_data_b;
    logic [31:0]       addr1_b, addr2_b, addr_write_b;

    mem_pair_sched #(.IMG_ROWS(4), .IMG_COLS(8), .LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_col(in_col_b),
        .op_issue(op_issue_b), .res_data(res_data_b), .addr1(addr1_b), .addr2(addr2_b),
        .we(we_b), .addr_write(addr_write_b), .write_data(write_data_b)
    );

    // ---------------- memory + compute models ----------------
    logic [3:0][31:0] mem_a [4];
    logic [3:0][31:0] pipe_a [2];
    logic [3:0][31:0] mem_b [8];
    logic [3:0][31:0] pipe_b [3];

    always @(posedge clk) begin
        if (we) mem_a[addr_write[1:0]] <= write_data;
        for (int r = 0; r < 4; r++) pipe_a[0][r] <= mem_a[addr1[1:0]][r] + mem_a[addr2[1:0]][r];
        pipe_a[1] <= pipe_a[0];
    end
    assign res_data = pipe_a[1];

    always @(posedge clk) begin
        if (we_b) mem_b[addr_write_b[2:0]] <= write_data_b;
        for (int r = 0; r < 4; r++) pipe_b[0][r] <= mem_b[addr1_b[2:0]][r] + mem_b[addr2_b[2:0]][r];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign res_data_b = pipe_b[2];

    // ---------------- observation / vector types ----------------
    typedef struct packed {
        logic             busy;
        logic             done;
        logic             rdy;
        logic             iss;
        logic [31:0]      a1;
        logic [31:0]      a2;
        logic             we;
        logic [31:0]      aw;
        logic [3:0][31:0] wd;
    } obs_t;

    typedef struct {
        logic rs;
        logic st;
        logic iv;
        int   col;
        obs_t e;
    } vec_t;

    obs_t obs;
    assign obs = {busy, done, in_ready, op_issue, addr1, addr2, we, addr_write, write_data};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t o(logic b, logic d, logic r, logic i, int a1, int a2,
                               logic w, int aw, int wv);
        obs_t x;
        x.busy = b;  x.done = d;  x.rdy = r;  x.iss = i;
        x.a1 = 32'(a1);  x.a2 = 32'(a2);
        x.we = w;  x.aw = 32'(aw);
        x.wd = {4{32'(wv)}};
        return x;
    endfunction

    function automatic vec_t mv(logic rs, logic st, logic iv, int col, obs_t e);
        vec_t v;
        v.rs = rs;  v.st = st;  v.iv = iv;  v.col = col;  v.e = e;
        return v;
    endfunction

    function automatic obs_t zo();
        return o(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Start pulse followed by columns 1..4 back to back (writes to 0..3).
    function automatic vec_t load_vec(int i, logic hold);
        if (i == 0) return mv(0, 1, 0, 0, zo());
        return mv(0, hold, 1, i, o(1, 0, 1, 0, 0, 0, 1, i - 1, i));
    endfunction

    // Reduction of columns 1,2,3,4 with LAT=2:
    // (0,1),(2,3), drain writes 0<-3, 2<-7, then (0,2), drain writes 0<-10, FIN, IDLE.
    function automatic vec_t reduce_vec(int i, logic st);
        case (i)
            0: return mv(0, st, 0, 0, o(1, 0, 0, 1, 0, 1, 0, 0, 0));
            1: return mv(0, st, 0, 0, o(1, 0, 0, 1, 2, 3, 0, 0, 0));
            2: return mv(0, st, 0, 0, o(1, 0, 0, 0, 0, 0, 1, 0, 3));
            3: return mv(0, st, 0, 0, o(1, 0, 0, 0, 0, 0, 1, 2, 7));
            4: return mv(0, st, 0, 0, o(1, 0, 0, 1, 0, 2, 0, 0, 0));
            5: return mv(0, st, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0));
            6: return mv(0, st, 0, 0, o(1, 0, 0, 0, 0, 0, 1, 0, 10));
            7: return mv(0, st, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0));
            default: return mv(0, st, 0, 0, zo());
        endcase
    endfunction

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        rst      = v.rs;
        start    = v.st;
        in_valid = v.iv;
        in_col   = {4{32'(v.col)}};
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vec_t q[$];
        q.push_back(mv(1, 0, 0, 0, zo()));
        q.push_back(mv(1, 1, 1, 5, zo()));
        q.push_back(mv(0, 0, 0, 0, zo()));
        q.push_back(mv(0, 0, 1, 0, zo()));
        foreach (q[i]) begin
            apply_vec(q[i]);
            n_checks++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h, expected %h", i, obs, q[i].e);
            end
        end
    endtask

    task automatic test_load();
        vec_t q[$];
        for (int i = 0; i < 5; i++) q.push_back(load_vec(i, 0));
        foreach (q[i]) begin
            apply_vec(q[i]);
            n_checks++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL load[%0d]: got %h, expected %h", i, obs, q[i].e);
            end
        end
    endtask

    task automatic test_reduce();
        vec_t q[$];
        for (int i = 0; i < 9; i++) q.push_back(reduce_vec(i, 0));
        foreach (q[i]) begin
            apply_vec(q[i]);
            n_checks++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL reduce[%0d]: got %h, expected %h", i, obs, q[i].e);
            end
        end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (mem_a[0][r] !== 32'd10) begin
                n_fail++;
                $display("FAIL reduce_col0 lane %0d: got %0d, expected 10", r, mem_a[0][r]);
            end
        end
    endtask

    task automatic test_stall();
        vec_t q[$];
        q.push_back(load_vec(0, 0));
        q.push_back(load_vec(1, 0));
        q.push_back(load_vec(2, 0));
        for (int g = 0; g < 3; g++) q.push_back(mv(0, 0, 0, 0, o(1, 0, 1, 0, 0, 0, 0, 0, 0)));
        q.push_back(load_vec(3, 0));
        q.push_back(load_vec(4, 0));
        for (int i = 0; i < 9; i++) q.push_back(reduce_vec(i, 0));
        foreach (q[i]) begin
            apply_vec(q[i]);
            n_checks++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h, expected %h", i, obs, q[i].e);
            end
        end
        n_checks++;
        if (mem_a[0] !== {4{32'd10}}) begin
            n_fail++;
            $display("FAIL stall_col0: got %h, expected all lanes 10", mem_a[0]);
        end
    endtask

    task automatic test_start_held();
        vec_t q[$];
        for (int i = 0; i < 5; i++) q.push_back(load_vec(i, 1));
        for (int i = 0; i < 9; i++) q.push_back(reduce_vec(i, 1));
        // start still high in IDLE after done: a second job begins (LOAD, idle loader).
        q.push_back(mv(0, 0, 0, 0, o(1, 0, 1, 0, 0, 0, 0, 0, 0)));
        foreach (q[i]) begin
            apply_vec(q[i]);
            n_checks++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL start_held[%0d]: got %h, expected %h", i, obs, q[i].e);
            end
        end
    endtask

    task automatic test_mid_reset();
        vec_t q[$];
        q.push_back(mv(1, 0, 0, 0, zo()));
        q.push_back(mv(0, 0, 0, 0, zo()));
        for (int i = 0; i < 5; i++) q.push_back(load_vec(i, 0));
        q.push_back(reduce_vec(0, 0));
        q.push_back(mv(1, 0, 0, 0, zo()));
        for (int i = 0; i < 4; i++) q.push_back(mv(0, 0, 0, 0, zo()));
        for (int i = 0; i < 5; i++) q.push_back(load_vec(i, 0));
        for (int i = 0; i < 9; i++) q.push_back(reduce_vec(i, 0));
        foreach (q[i]) begin
            apply_vec(q[i]);
            n_checks++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: got %h, expected %h", i, obs, q[i].e);
            end
        end
        n_checks++;
        if (mem_a[0] !== {4{32'd10}}) begin
            n_fail++;
            $display("FAIL mid_reset_col0: got %h, expected all lanes 10", mem_a[0]);
        end
    endtask

    // Columns 1..8, LAT=3: stage pair counts 4,2,1; writebacks 3,7,11,15 / 10,26 / 36.
    task automatic test_cols8();
        int iss_cyc[$], iss_a1[$], iss_a2[$];
        int wb_cyc[$], wb_addr[$], wb_val[$];
        int done_cyc = -1;
        int exp_iss_cyc[7] = '{0, 1, 2, 3, 7, 8, 12};
        int exp_a1[7]      = '{0, 2, 4, 6, 0, 4, 0};
        int exp_a2[7]      = '{1, 3, 5, 7, 2, 6, 4};
        int exp_wb_cyc[7]  = '{3, 4, 5, 6, 10, 11, 15};
        int exp_wb_addr[7] = '{0, 2, 4, 6, 0, 4, 0};
        int exp_wb_val[7]  = '{3, 7, 11, 15, 10, 26, 36};

        @(negedge clk);
        start_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start_b    = 1'b0;
            in_valid_b = 1'b1;
            in_col_b   = {4{32'(k)}};
        end
        for (int k = 0; k < 60 && done_cyc < 0; k++) begin
            @(negedge clk);
            in_valid_b = 1'b0;
            in_col_b   = '0;
            #1;
            if (op_issue_b) begin
                iss_cyc.push_back(k);
                iss_a1.push_back(int'(addr1_b));
                iss_a2.push_back(int'(addr2_b));
            end
            if (we_b) begin
                wb_cyc.push_back(k);
                wb_addr.push_back(int'(addr_write_b));
                wb_val.push_back(int'(write_data_b[0]));
            end
            if (done_b) done_cyc = k;
        end

        n_checks++;
        if (done_cyc != 16) begin
            n_fail++;
            $display("FAIL cols8_done: done at cycle %0d, expected 16 (-1 = timeout)", done_cyc);
        end
        n_checks++;
        if (iss_cyc.size() != 7) begin
            n_fail++;
            $display("FAIL cols8_issue_count: got %0d, expected 7", iss_cyc.size());
        end
        n_checks++;
        if (wb_cyc.size() != 7) begin
            n_fail++;
            $display("FAIL cols8_wb_count: got %0d, expected 7", wb_cyc.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < iss_cyc.size()) begin
                n_checks++;
                if (iss_cyc[i] != exp_iss_cyc[i] || iss_a1[i] != exp_a1[i] || iss_a2[i] != exp_a2[i]) begin
                    n_fail++;
                    $display("FAIL cols8_issue[%0d]: got cyc %0d (%0d,%0d), expected cyc %0d (%0d,%0d)",
                             i, iss_cyc[i], iss_a1[i], iss_a2[i], exp_iss_cyc[i], exp_a1[i], exp_a2[i]);
                end
            end
            if (i < wb_cyc.size()) begin
                n_checks++;
                if (wb_cyc[i] != exp_wb_cyc[i] || wb_addr[i] != exp_wb_addr[i] || wb_val[i] != exp_wb_val[i]) begin
                    n_fail++;
                    $display("FAIL cols8_wb[%0d]: got cyc %0d addr %0d val %0d, expected cyc %0d addr %0d val %0d",
                             i, wb_cyc[i], wb_addr[i], wb_val[i], exp_wb_cyc[i], exp_wb_addr[i], exp_wb_val[i]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (mem_b[0] !== {4{32'd36}} || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL cols8_final: col0 %h busy %b, expected all lanes 36 and busy 0", mem_b[0], busy_b);
        end
    endtask

    // ---------------- clock, watchdog, sequence ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_col     = '0;
        start_b    = 1'b0;
        in_valid_b = 1'b0;
        in_col_b   = '0;

        test_reset();
        test_load();
        test_reduce();
        test_stall();
        test_start_held();
        test_mid_reset();
        test_cols8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_pair_sched.md
MEM_PAIR_SCHED -- requirements
Module: mem_pair_sched

Interface
REQ-001 SHALL have parameter IMG_ROWS, default 4, meaning rows per column word (one 32-bit lane per row).
REQ-002 SHALL have parameter IMG_COLS, default 4, meaning column count; power of two, >= 2.
REQ-003 SHALL have parameter LAT, default 2, meaning cycles from pair issue to res_data valid; >= 1.
REQ-004 Ports SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load+reduce job; sampled only in IDLE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at job completion.
- in_valid  input  1  loader column valid.
- in_ready  output  1  loader column accepted when in_valid && in_ready.
- in_col  input  [IMG_ROWS-1:0][31:0]  loader column data.
- op_issue  output  1  addr1/addr2 carry a valid pair this cycle.
- res_data  input  [IMG_ROWS-1:0][31:0]  compute result, valid LAT cycles after its op_issue.
- addr1, addr2  output  32  memory read addresses.
- we  output  1  memory write enable.
- addr_write  output  32  memory write address.
- write_data  output  [IMG_ROWS-1:0][31:0]  memory write data.

Function
REQ-005 SHALL implement states IDLE, LOAD, REDUCE, DRAIN, FIN.
REQ-006 IDLE: start=1 -> LOAD, load counter cleared; start in any other state SHALL be ignored.
REQ-007 LOAD: in_ready=1; each handshake SHALL drive we=1, addr_write=load counter, write_data=in_col combinationally in the same cycle, then increment the counter.
REQ-008 LOAD SHALL move to REDUCE after the handshake at counter IMG_COLS-1; in_ready SHALL be 0 in every other state.
REQ-009 REDUCE: for stage s = 0..log2(IMG_COLS)-1, span = 2^s, SHALL issue one pair per cycle (op_issue=1, addr1=i, addr2=i+span) for i = 0, 2*span, 4*span, ... < IMG_COLS, ascending.
REQ-010 Each issue SHALL push addr1 into an LAT-deep valid/address delay line; when an entry emerges, SHALL drive we=1, addr_write=that address, write_data=res_data.
REQ-011 After the last pair of a stage, SHALL enter DRAIN with op_issue=0 until the delay line is empty; then start the next stage in REDUCE, or go to FIN after the final stage.
REQ-012 FIN SHALL assert done for exactly one cycle, then return to IDLE; column 0 then holds the full reduction.
REQ-013 Outside LOAD handshakes and delay-line writes, we SHALL be 0; a LOAD write and a REDUCE writeback SHALL never coincide.
REQ-014 Upper address bits above $clog2(IMG_COLS) SHALL be 0; addr1/addr2 SHALL hold 0 when op_issue=0.
REQ-015 in_valid low in LOAD SHALL stall without state change; no timeout.

Reset
REQ-016 rst=1 SHALL immediately force IDLE and clear counters, stage index and every delay-line valid bit.
REQ-017 During and after reset until the next job: busy=0, done=0, in_ready=0, op_issue=0, we=0, addr1=addr2=addr_write=0, write_data=0.
REQ-018 Reset mid-REDUCE/DRAIN SHALL cause no writeback of in-flight results after rst deasserts.

Verification (IMG_ROWS=4, IMG_COLS=4, LAT=2)
REQ-019 Load columns 1,2,3,4 (all lanes equal), back-to-back in_valid -> writes to addresses 0..3 on 4 consecutive cycles, then REDUCE.
REQ-020 Reduction with res_data = lane-sum model -> issues (0,1),(2,3) on consecutive cycles, 2-cycle drain, then (0,2); writes to 0,2,0; done pulses once; column 0 = 10 per lane.
REQ-021 in_valid deasserted 3 cycles after 2nd column -> in_ready stays 1, no write during the gap, the 3rd column is written to address 2.
REQ-022 start held high through an entire job -> exactly one job runs; a new job starts only when start is sampled in IDLE after done.
REQ-023 rst pulsed on the cycle after the (0,1) issue -> we stays 0 for LAT+2 cycles after release; busy=0; a fresh job then completes correctly.
REQ-024 IMG_COLS=8, LAT=3 -> stage pair counts 4,2,1; each stage's first issue follows the previous stage's last writeback by at least 1 cycle.
